// File: rtl/lt24_frame_streamer_if.sv
// rtl/lt24_frame_streamer_if.sv - pixel RAM read ports and LT24 parallel bus
interface lt24_frame_streamer_if #(
    parameter int ADDR_W = 13
) ();
    logic [ADDR_W-1:0] bg_address;
    logic              bg_chipselect;
    logic              bg_clken;
    logic [15:0]       bg_readdata;
    logic [ADDR_W-1:0] pic_address;
    logic              pic_chipselect;
    logic              pic_clken;
    logic [15:0]       pic_readdata;
    logic              lt24_cs;
    logic              lt24_rs;
    logic              lt24_rd;
    logic              lt24_wr;
    logic [15:0]       lt24_data;

    modport master (
        output bg_address, bg_chipselect, bg_clken,
        input  bg_readdata,
        output pic_address, pic_chipselect, pic_clken,
        input  pic_readdata,
        output lt24_cs, lt24_rs, lt24_rd, lt24_wr, lt24_data
    );

    modport slave (
        input  bg_address, bg_chipselect, bg_clken,
        output bg_readdata,
        input  pic_address, pic_chipselect, pic_clken,
        output pic_readdata,
        input  lt24_cs, lt24_rs, lt24_rd, lt24_wr, lt24_data
    );
endinterface

// File: rtl/lt24_frame_streamer.sv
// rtl/lt24_frame_streamer.sv - one LT24 frame refresh: memory-write command then NPIX composited pixels
module lt24_frame_streamer #(
    parameter int          ADDR_W      = 13,
    parameter int          NPIX        = 8192,
    parameter int          WR_LOW_CYC  = 1,
    parameter int          WR_HIGH_CYC = 1,
    parameter logic [15:0] KEY         = 16'hF81F
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] fill_color,
    output logic        busy,
    output logic        finish_flag,
    output logic [31:0] counter,
    lt24_frame_streamer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, CMD_L, CMD_H, FETCH, LATCH, PIX_L, PIX_H, DONE
    } state_t;

    localparam logic [15:0]       LO_LAST  = 16'(WR_LOW_CYC - 1);
    localparam logic [15:0]       HI_LAST  = 16'(WR_HIGH_CYC - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NPIX - 1);

    state_t            state_q, state_d;
    logic [15:0]       ph_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        mode_q;
    logic [15:0]       fill_q;
    logic [15:0]       pix_q;
    logic [15:0]       pix_sel;
    logic              last_pix;

    assign last_pix = (addr_q == PIX_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CMD_L;
            CMD_L:   if (ph_q == LO_LAST) state_d = CMD_H;
            CMD_H:   if (ph_q == HI_LAST) state_d = FETCH;
            FETCH:   state_d = LATCH;
            LATCH:   state_d = PIX_L;
            PIX_L:   if (ph_q == LO_LAST) state_d = PIX_H;
            PIX_H:   if (ph_q == HI_LAST) state_d = last_pix ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pix_sel = pic_sel_default();
        case (mode_q)
            2'b00:   pix_sel = (bus.pic_readdata == KEY) ? bus.bg_readdata : bus.pic_readdata;
            2'b01:   pix_sel = bus.bg_readdata;
            2'b10:   pix_sel = bus.pic_readdata;
            default: pix_sel = fill_q;
        endcase
    end

    function automatic logic [15:0] pic_sel_default();
        return 16'h0000;
    endfunction

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            ph_q    <= '0;
            addr_q  <= '0;
            counter <= '0;
            mode_q  <= '0;
            fill_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= (state_d != state_q) ? 16'd0 : ph_q + 16'd1;
            if (state_q == IDLE && start) begin
                mode_q  <= mode;
                fill_q  <= fill_color;
                counter <= '0;
                addr_q  <= '0;
                // The command word travels through the pixel register so the bus data is always registered
                pix_q   <= 16'h002C;
            end else if (state_q != IDLE && counter != 32'hFFFF_FFFF) begin
                counter <= counter + 32'd1;
            end
            if (state_q == LATCH)
                pix_q <= pix_sel;
            if (state_q == PIX_H && state_d != PIX_H)
                addr_q <= last_pix ? '0 : addr_q + 1'b1;
        end
    end

    assign busy        = (state_q != IDLE);
    assign finish_flag = (state_q == DONE);

    assign bus.bg_address     = addr_q;
    assign bus.pic_address    = addr_q;
    assign bus.bg_chipselect  = (state_q == FETCH);
    assign bus.bg_clken       = (state_q == FETCH);
    assign bus.pic_chipselect = (state_q == FETCH);
    assign bus.pic_clken      = (state_q == FETCH);

    assign bus.lt24_cs   = (state_q == IDLE) || (state_q == DONE);
    assign bus.lt24_rs   = !((state_q == CMD_L) || (state_q == CMD_H));
    assign bus.lt24_rd   = 1'b1;
    assign bus.lt24_wr   = !((state_q == CMD_L) || (state_q == PIX_L));
    assign bus.lt24_data = pix_q;
endmodule

// File: tb/tb_lt24_frame_streamer.sv
// tb/tb_lt24_frame_streamer.sv - directed table-driven bench for lt24_frame_streamer
module tb_lt24_frame_streamer;
    localparam logic [15:0] KEY = 16'hF81F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn  = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [1:0]  mode    = 2'b00;
    logic [15:0] fill    = 16'h0000;
    logic        busy_a, busy_b, busy_c, fin_a, fin_b, fin_c;
    logic [31:0] cnt_a, cnt_b, cnt_c;

    lt24_frame_streamer_if #(.ADDR_W(13)) a_if ();
    lt24_frame_streamer_if #(.ADDR_W(13)) b_if ();
    lt24_frame_streamer_if #(.ADDR_W(13)) c_if ();

    lt24_frame_streamer #(.ADDR_W(13), .NPIX(4), .WR_LOW_CYC(1), .WR_HIGH_CYC(1), .KEY(KEY)) dut_a (
        .clk_clk(clk), .reset_reset_n(resetn), .start(start_a), .mode(mode), .fill_color(fill),
        .busy(busy_a), .finish_flag(fin_a), .counter(cnt_a), .bus(a_if.master));
    lt24_frame_streamer #(.ADDR_W(13), .NPIX(4), .WR_LOW_CYC(2), .WR_HIGH_CYC(3), .KEY(KEY)) dut_b (
        .clk_clk(clk), .reset_reset_n(resetn), .start(start_b), .mode(mode), .fill_color(fill),
        .busy(busy_b), .finish_flag(fin_b), .counter(cnt_b), .bus(b_if.master));
    lt24_frame_streamer dut_c (
        .clk_clk(clk), .reset_reset_n(resetn), .start(start_c), .mode(mode), .fill_color(fill),
        .busy(busy_c), .finish_flag(fin_c), .counter(cnt_c), .bus(c_if.master));

    logic [15:0] bg_mem [4];
    logic [15:0] pic_mem[4];

    always @(posedge clk) begin
        if (a_if.bg_chipselect && a_if.bg_clken)   a_if.bg_readdata  <= bg_mem[a_if.bg_address[1:0]];
        if (a_if.pic_chipselect && a_if.pic_clken) a_if.pic_readdata <= pic_mem[a_if.pic_address[1:0]];
        if (b_if.bg_chipselect && b_if.bg_clken)   b_if.bg_readdata  <= bg_mem[b_if.bg_address[1:0]];
        if (b_if.pic_chipselect && b_if.pic_clken) b_if.pic_readdata <= pic_mem[b_if.pic_address[1:0]];
        if (c_if.bg_chipselect && c_if.bg_clken)   c_if.bg_readdata  <= {3'b000, c_if.bg_address};
        if (c_if.pic_chipselect && c_if.pic_clken) c_if.pic_readdata <= {3'b111, c_if.pic_address};
    end

    // Bus write log for instance A: one {rs,data} entry per falling edge of wr
    logic [16:0] a_wq[$];
    logic        a_wr_prev = 1'b1;
    int          a_fin_cnt = 0;
    always @(negedge clk) begin
        a_wr_prev <= a_if.lt24_wr;
        if (a_wr_prev && !a_if.lt24_wr) a_wq.push_back({a_if.lt24_rs, a_if.lt24_data});
        if (fin_a) a_fin_cnt <= a_fin_cnt + 1;
    end

    int b_lo = 0, b_hi = 0;
    bit b_hv = 1'b0;
    int b_lo_q[$], b_hi_q[$];
    always @(negedge clk) begin
        if (!b_if.lt24_cs) begin
            if (!b_if.lt24_wr) begin
                b_lo <= b_lo + 1;
                b_hi <= 0;
                b_hv <= 1'b0;
                if (b_hv) b_hi_q.push_back(b_hi);
            end else begin
                b_hi <= b_hi + 1;
                if (b_lo != 0) begin
                    b_lo_q.push_back(b_lo);
                    b_lo <= 0;
                    b_hv <= 1'b1;
                end
            end
        end
    end

    int          c_fetch = 0, c_bad = 0;
    logic [12:0] c_exp = '0, c_last = '0;
    always @(negedge clk) begin
        if (c_if.bg_chipselect) begin
            c_fetch <= c_fetch + 1;
            if (c_if.bg_address != c_exp || c_if.pic_address != c_if.bg_address
                || !c_if.bg_clken || !c_if.pic_clken || !c_if.pic_chipselect)
                c_bad <= c_bad + 1;
            c_exp  <= c_exp + 13'd1;
            c_last <= c_if.bg_address;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int which);
        @(negedge clk);
        case (which)
            0:       start_a = 1'b1;
            1:       start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic wait_idle(input int which, input int bound, input string name);
        int   n;
        logic b;
        for (n = 0; n < bound; n++) begin
            b = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
            if (!b) break;
            @(negedge clk);
        end
        check({name, " completes"}, 32'(n < bound), 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [3:0][15:0] exp);
        check({tag, " nwrites"}, a_wq.size(), 32'd5);
        if (a_wq.size() == 5) begin
            check({tag, " cmd"}, 32'(a_wq[0]), {15'd0, 1'b0, 16'h002C});
            for (int k = 0; k < 4; k++)
                check($sformatf("%s px%0d", tag, k), 32'(a_wq[k+1]), {15'd0, 1'b1, exp[k]});
        end
    endtask

    typedef struct packed {
        logic [1:0]       mode;
        logic [15:0]      fill;
        logic [3:0][15:0] pic;
        logic [3:0][15:0] bg;
        logic [3:0][15:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic load_ram(input int i);
        for (int k = 0; k < 4; k++) begin
            bg_mem[k]  = vecs[i].bg[k];
            pic_mem[k] = vecs[i].pic[k];
        end
        mode = vecs[i].mode;
        fill = vecs[i].fill;
    endtask

    initial begin
        int fin0;
        int n;
        // Packed lists are written highest index first: {px3, px2, px1, px0}
        vecs[0] = '{2'b00, 16'h0000, {16'h0003, KEY, 16'h0001, KEY}, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
                    {16'h0003, 16'hCCCC, 16'h0001, 16'hAAAA}};
        vecs[1] = '{2'b01, 16'h0000, {16'h0003, KEY, 16'h0001, KEY}, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
                    {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}};
        vecs[2] = '{2'b10, 16'h0000, {16'h0003, KEY, 16'h0001, KEY}, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
                    {16'h0003, KEY, 16'h0001, KEY}};
        vecs[3] = '{2'b11, 16'h07E0, {16'h0003, KEY, 16'h0001, KEY}, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
                    {16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0}};
        vecs[4] = '{2'b00, 16'h0000, {KEY, KEY, KEY, KEY}, {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234},
                    {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}};
        vecs[5] = '{2'b00, 16'h0000, {16'h7BEF, 16'hFFFF, 16'h0000, 16'hF81E}, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA},
                    {16'h7BEF, 16'hFFFF, 16'h0000, 16'hF81E}};

        repeat (3) @(negedge clk);
        check("rst busy",    32'(busy_a), 32'd0);
        check("rst finish",  32'(fin_a), 32'd0);
        check("rst counter", cnt_a, 32'd0);
        check("rst cs",      32'(a_if.lt24_cs), 32'd1);
        check("rst rs",      32'(a_if.lt24_rs), 32'd1);
        check("rst rd",      32'(a_if.lt24_rd), 32'd1);
        check("rst wr",      32'(a_if.lt24_wr), 32'd1);
        check("rst data",    32'(a_if.lt24_data), 32'd0);
        check("rst ramsel",  32'({a_if.bg_chipselect, a_if.bg_clken, a_if.pic_chipselect, a_if.pic_clken}), 32'd0);
        resetn = 1'b1;

        load_ram(0);
        pulse_start(2);
        wait_idle(2, 40000, "default frame");
        check("default fetches",  c_fetch, 32'd8192);
        check("default addr seq", c_bad, 32'd0);
        check("default last addr", 32'(c_last), 32'd8191);
        check("default counter",  cnt_c, 32'd32771);
        check("default addr wrap", 32'(c_if.bg_address), 32'd0);

        for (int i = 0; i < 6; i++) begin
            load_ram(i);
            a_wq.delete();
            fin0 = a_fin_cnt;
            pulse_start(0);
            wait_idle(0, 100, $sformatf("v%0d", i));
            check_writes($sformatf("v%0d", i), vecs[i].exp);
            check($sformatf("v%0d counter", i), cnt_a, 32'd19);
            check($sformatf("v%0d finish count", i), 32'(a_fin_cnt - fin0), 32'd1);
        end

        load_ram(0);
        a_wq.delete();
        fin0 = a_fin_cnt;
        pulse_start(0);
        repeat (6) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle(0, 100, "midstart");
        check_writes("midstart", vecs[0].exp);
        check("midstart counter", cnt_a, 32'd19);
        check("midstart finish count", 32'(a_fin_cnt - fin0), 32'd1);

        fin0 = a_fin_cnt;
        pulse_start(0);
        for (n = 0; n < 100; n++) begin
            if (fin_a) break;
            @(negedge clk);
        end
        check("done reached", 32'(n < 100), 32'd1);
        start_a = 1'b1;
        @(negedge clk);
        check("start at done ignored", 32'(busy_a), 32'd0);
        check("counter held in idle", cnt_a, 32'd19);
        @(negedge clk);
        check("start after done accepted", 32'(busy_a), 32'd1);
        check("counter cleared on start", cnt_a, 32'd0);
        start_a = 1'b0;
        wait_idle(0, 100, "restart");
        check("restart counter", cnt_a, 32'd19);
        check("restart finish count", 32'(a_fin_cnt - fin0), 32'd2);

        pulse_start(0);
        for (n = 0; n < 100; n++) begin
            if (!a_if.lt24_wr && a_if.lt24_rs) break;
            @(negedge clk);
        end
        check("pix_l reached", 32'(n < 100), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst cs",      32'(a_if.lt24_cs), 32'd1);
        check("midrst wr",      32'(a_if.lt24_wr), 32'd1);
        check("midrst busy",    32'(busy_a), 32'd0);
        check("midrst counter", cnt_a, 32'd0);
        check("midrst data",    32'(a_if.lt24_data), 32'd0);
        check("midrst addr",    32'(a_if.bg_address), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        a_wq.delete();
        pulse_start(0);
        wait_idle(0, 100, "after reset");
        check_writes("after reset", vecs[0].exp);
        check("after reset counter", cnt_a, 32'd19);

        pulse_start(1);
        wait_idle(1, 200, "slow wr");
        check("slow counter", cnt_b, 32'd34);
        check("slow low runs", b_lo_q.size(), 32'd5);
        foreach (b_lo_q[k]) check($sformatf("slow low%0d", k), b_lo_q[k], 32'd2);
        check("slow high gaps", b_hi_q.size(), 32'd4);
        foreach (b_hi_q[k]) check($sformatf("slow gap%0d", k), b_hi_q[k], 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
